// File: rtl/protocol_rx.sv
// -----------------------------------------------------------------------------
// protocol_rx - SPI frame decoder for the LED-lamp frame buffer.
//
// Samples the SPI bus in the i_clk domain through input synchronisers, parses
// cmd/len frames and turns payload data words into frame-buffer write strobes.
// Keyframe headers are held in shadow registers and committed only when the
// frame completes. Aborts, unknown commands and address overflow are flagged.
//
// Ports:
//   i_clk       system clock
//   i_rst       asynchronous active-high reset
//   i_dck       SPI clock (asynchronous, at most i_clk/4)
//   i_cs        SPI chip select, active low (asynchronous)
//   i_mosi      SPI data, MSB first (asynchronous)
//   o_wen       one-cycle write strobe
//   o_addr      write address, valid with o_wen
//   o_data      write data, valid with o_wen
//   o_type      committed keyframe type
//   o_time      committed keyframe duration
//   o_ready     one-cycle frame-complete pulse
//   o_err       one-cycle error pulse
//   o_err_code  last error cause: 1 abort, 2 unknown command, 3 address overflow
// -----------------------------------------------------------------------------
module protocol_rx #(
    parameter int c_ledboards = 30,
    parameter int c_bpc       = 12,
    parameter int c_cmd_w     = 5,
    parameter int c_len_w     = 11,
    parameter int c_type_w    = 6,
    parameter int c_time_w    = 10,
    parameter int c_off_w     = 16,
    parameter int c_sync      = 2,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_ledboards * 32)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_dck,
    input  logic                i_cs,
    input  logic                i_mosi,
    output logic                o_wen,
    output logic [c_addr_w-1:0] o_addr,
    output logic [c_bpc-1:0]    o_data,
    output logic [c_type_w-1:0] o_type,
    output logic [c_time_w-1:0] o_time,
    output logic                o_ready,
    output logic                o_err,
    output logic [1:0]          o_err_code
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shift register serves every header field; it must hold the widest one.
    localparam int c_fld_w = max2(max2(max2(c_cmd_w, c_len_w), max2(c_type_w, c_time_w)), c_off_w);
    localparam int c_fc_w  = $clog2(c_fld_w + 1);
    localparam int c_wc_w  = $clog2(c_bpc);
    localparam int c_acc_w = c_off_w + 1;

    localparam logic [c_fc_w-1:0]  c_fc_one    = c_fc_w'(1);
    localparam logic [c_fc_w-1:0]  c_cmd_last  = c_fc_w'(c_cmd_w - 1);
    localparam logic [c_fc_w-1:0]  c_len_last  = c_fc_w'(c_len_w - 1);
    localparam logic [c_fc_w-1:0]  c_type_last = c_fc_w'(c_type_w - 1);
    localparam logic [c_fc_w-1:0]  c_time_last = c_fc_w'(c_time_w - 1);
    localparam logic [c_fc_w-1:0]  c_off_last  = c_fc_w'(c_off_w - 1);
    localparam logic [c_wc_w-1:0]  c_wc_one    = c_wc_w'(1);
    localparam logic [c_wc_w-1:0]  c_bpc_last  = c_wc_w'(c_bpc - 1);
    localparam logic [c_acc_w-1:0] c_acc_one   = c_acc_w'(1);
    localparam logic [c_acc_w-1:0] c_acc_lim   = c_acc_w'(c_channels);
    localparam logic [c_len_w-1:0] c_len_one   = c_len_w'(1);
    localparam logic [c_cmd_w-1:0] c_cmd_key   = '0;
    localparam logic [c_cmd_w-1:0] c_cmd_off   = c_cmd_w'(1);

    localparam logic [1:0] c_err_abort = 2'd1;
    localparam logic [1:0] c_err_cmd   = 2'd2;
    localparam logic [1:0] c_err_ovf   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_DONE
    } state_t;

    // Where we are inside the payload; chosen by cmd when LEN completes.
    typedef enum logic [2:0] {
        PH_TYPE,
        PH_TIME,
        PH_OFF,
        PH_DATA,
        PH_SKIP
    } phase_t;

    // ------------------------------------------------------------------
    // Input path: synchronisers, edge register, registered bit event.
    // ------------------------------------------------------------------
    logic [c_sync-1:0] dck_sync;
    logic [c_sync-1:0] cs_sync;
    logic [c_sync-1:0] mosi_sync;
    logic              dck_prev;
    logic              cs_prev;
    logic              ev;
    logic              bit_in;
    logic              cs_rise;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge value of its neighbours; with = the synchroniser chain would
    // collapse into a single stage.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            dck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
            ev        <= 1'b0;
            bit_in    <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            dck_sync  <= {dck_sync[c_sync-2:0], i_dck};
            cs_sync   <= {cs_sync[c_sync-2:0], i_cs};
            mosi_sync <= {mosi_sync[c_sync-2:0], i_mosi};
            dck_prev  <= dck_sync[c_sync-1];
            cs_prev   <= cs_sync[c_sync-1];
            // Gating with the previous cs lets a final dck edge that arrives
            // together with cs rising still count as a bit.
            ev        <= dck_sync[c_sync-1] & ~dck_prev & ~cs_prev;
            bit_in    <= mosi_sync[c_sync-1];
            cs_rise   <= cs_sync[c_sync-1] & ~cs_prev;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser state.
    // ------------------------------------------------------------------
    state_t               state;
    state_t               state_nx;
    phase_t               phase;
    logic [c_fld_w-2:0]   fld;
    logic [c_fld_w-1:0]   shifted;
    logic [c_fc_w-1:0]    fcnt;
    logic [c_cmd_w-1:0]   cmd_q;
    logic [c_len_w-1:0]   byte_cnt;
    logic [2:0]           bib;
    logic [c_wc_w-1:0]    wcnt;
    logic [c_bpc-2:0]     word;
    logic [c_acc_w-1:0]   addr_acc;
    logic [c_type_w-1:0]  type_sh;
    logic [c_time_w-1:0]  time_sh;
    logic                 ovf_seen;
    logic                 fin;

    logic                 busy;
    logic                 cmd_done;
    logic                 len_done;
    logic [c_len_w-1:0]   len_val;
    logic                 final_bit;
    logic                 abort;
    logic                 take;

    assign shifted   = {fld, bit_in};
    assign len_val   = shifted[c_len_w-1:0];
    assign busy      = (state == S_CMD) || (state == S_LEN) || (state == S_PAYLOAD);
    assign cmd_done  = (fcnt == c_cmd_last);
    assign len_done  = (fcnt == c_len_last);
    assign final_bit = ((state == S_LEN) && len_done && (len_val == '0)) ||
                       ((state == S_PAYLOAD) && (bib == 3'd7) && (byte_cnt == c_len_one));
    // A cs rise that coincides with the frame's last bit, or arrives while the
    // completion is already pending, does not abort.
    assign abort     = cs_rise && busy && !fin && !(ev && final_bit);
    assign take      = ev && !abort;
    assign o_ready   = (state == S_DONE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // fin is set by the frame's last bit and moves the FSM to DONE one cycle
    // later, so the last write strobe (E+1) always precedes o_ready (E+2).
    always_comb begin
        // NOTE: the default assignment first keeps this block free of latches
        // on every path that does not change state.
        state_nx = state;
        unique case (state)
            S_IDLE:    if (take) state_nx = S_CMD;
            S_CMD: begin
                if (abort)                 state_nx = S_IDLE;
                else if (take && cmd_done) state_nx = S_LEN;
            end
            S_LEN: begin
                if (abort)                                     state_nx = S_IDLE;
                else if (fin)                                  state_nx = S_DONE;
                else if (take && len_done && (len_val != '0))  state_nx = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                if (abort)    state_nx = S_IDLE;
                else if (fin) state_nx = S_DONE;
            end
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            phase      <= PH_TYPE;
            fld        <= '0;
            fcnt       <= '0;
            cmd_q      <= '0;
            byte_cnt   <= '0;
            bib        <= '0;
            wcnt       <= '0;
            word       <= '0;
            addr_acc   <= '0;
            type_sh    <= '0;
            time_sh    <= '0;
            ovf_seen   <= 1'b0;
            fin        <= 1'b0;
            o_wen      <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_type     <= '0;
            o_time     <= '0;
            o_err      <= 1'b0;
            o_err_code <= '0;
        end else begin
            o_wen <= 1'b0;
            o_err <= 1'b0;
            fin   <= 1'b0;

            if (abort) begin
                // Abort beats any overflow or word completion in this cycle.
                o_err      <= 1'b1;
                o_err_code <= c_err_abort;
            end else if (fin) begin
                if (cmd_q == c_cmd_key) begin
                    o_type <= type_sh;
                    o_time <= time_sh;
                end
            end else if (take) begin
                unique case (state)
                    S_IDLE: begin
                        fld      <= shifted[c_fld_w-2:0];
                        fcnt     <= c_fc_one;
                        ovf_seen <= 1'b0;
                    end
                    S_CMD: begin
                        fld <= shifted[c_fld_w-2:0];
                        if (cmd_done) begin
                            cmd_q <= shifted[c_cmd_w-1:0];
                            fcnt  <= '0;
                        end else begin
                            fcnt <= fcnt + c_fc_one;
                        end
                    end
                    S_LEN: begin
                        fld <= shifted[c_fld_w-2:0];
                        if (len_done) begin
                            fcnt     <= '0;
                            byte_cnt <= len_val;
                            bib      <= '0;
                            wcnt     <= '0;
                            fin      <= (len_val == '0);
                            if (cmd_q == c_cmd_key) begin
                                // Fresh shadows so a short keyframe commits zeros,
                                // not leftovers from an earlier aborted frame.
                                phase    <= PH_TYPE;
                                type_sh  <= '0;
                                time_sh  <= '0;
                                addr_acc <= '0;
                            end else if (cmd_q == c_cmd_off) begin
                                phase <= PH_OFF;
                            end else begin
                                phase      <= PH_SKIP;
                                o_err      <= 1'b1;
                                o_err_code <= c_err_cmd;
                            end
                        end else begin
                            fcnt <= fcnt + c_fc_one;
                        end
                    end
                    S_PAYLOAD: begin
                        bib <= bib + 3'd1;
                        if (bib == 3'd7) byte_cnt <= byte_cnt - c_len_one;
                        fin <= final_bit;
                        unique case (phase)
                            PH_TYPE: begin
                                fld <= shifted[c_fld_w-2:0];
                                if (fcnt == c_type_last) begin
                                    type_sh <= shifted[c_type_w-1:0];
                                    fcnt    <= '0;
                                    phase   <= PH_TIME;
                                end else begin
                                    fcnt <= fcnt + c_fc_one;
                                end
                            end
                            PH_TIME: begin
                                fld <= shifted[c_fld_w-2:0];
                                if (fcnt == c_time_last) begin
                                    time_sh <= shifted[c_time_w-1:0];
                                    fcnt    <= '0;
                                    phase   <= PH_DATA;
                                end else begin
                                    fcnt <= fcnt + c_fc_one;
                                end
                            end
                            PH_OFF: begin
                                fld <= shifted[c_fld_w-2:0];
                                if (fcnt == c_off_last) begin
                                    addr_acc <= {1'b0, shifted[c_off_w-1:0]};
                                    fcnt     <= '0;
                                    phase    <= PH_DATA;
                                end else begin
                                    fcnt <= fcnt + c_fc_one;
                                end
                            end
                            PH_DATA: begin
                                word <= {word[c_bpc-3:0], bit_in};
                                if (wcnt == c_bpc_last) begin
                                    wcnt     <= '0;
                                    // The accumulator is one bit wider than the
                                    // offset field, so it never wraps below the limit.
                                    addr_acc <= addr_acc + c_acc_one;
                                    if (addr_acc >= c_acc_lim) begin
                                        if (!ovf_seen) begin
                                            ovf_seen   <= 1'b1;
                                            o_err      <= 1'b1;
                                            o_err_code <= c_err_ovf;
                                        end
                                    end else begin
                                        o_wen  <= 1'b1;
                                        o_addr <= addr_acc[c_addr_w-1:0];
                                        o_data <= {word, bit_in};
                                    end
                                end else begin
                                    wcnt <= wcnt + c_wc_one;
                                end
                            end
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_protocol_rx.sv
// -----------------------------------------------------------------------------
// tb_protocol_rx - self-checking bench for protocol_rx.
//
// Drives SPI frames from one directed sequence (plus randomized frames) and
// compares the observed write strobes, error pulses, ready pulses and
// committed keyframe header against a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_protocol_rx;

    localparam int c_cmd_w = 5;
    localparam int c_len_w = 11;
    localparam int c_chan  = 960;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        dck  = 1'b0;
    logic        cs   = 1'b1;
    logic        mosi = 1'b0;
    logic        wen;
    logic [9:0]  addr;
    logic [11:0] data;
    logic [5:0]  typ;
    logic [9:0]  tim;
    logic        ready;
    logic        err;
    logic [1:0]  err_code;

    protocol_rx dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_dck      (dck),
        .i_cs       (cs),
        .i_mosi     (mosi),
        .o_wen      (wen),
        .o_addr     (addr),
        .o_data     (data),
        .o_type     (typ),
        .o_time     (tim),
        .o_ready    (ready),
        .o_err      (err),
        .o_err_code (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pay [0:63];

    // Observed per frame.
    logic [21:0] obs_w[$];
    logic [1:0]  obs_e[$];
    int          obs_rdy = 0;
    int          overlap = 0;
    int          cyc     = 0;
    int          wen_cyc = 0;
    int          rdy_cyc = 0;
    logic [5:0]  prev_type = '0;
    logic [9:0]  prev_time = '0;
    logic [5:0]  type_pre  = '0;
    logic [9:0]  time_pre  = '0;

    // Expected per frame.
    logic [21:0] exp_w[$];
    logic [1:0]  exp_e[$];
    int          exp_rdy  = 0;
    logic [5:0]  exp_type = '0;
    logic [9:0]  exp_time = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (wen) begin
                obs_w.push_back({addr, data});
                wen_cyc = cyc;
            end
            if (err) obs_e.push_back(err_code);
            if (ready) begin
                obs_rdy++;
                rdy_cyc  = cyc;
                type_pre = prev_type;
                time_pre = prev_time;
                if (wen) overlap++;
            end
            prev_type = typ;
            prev_time = tim;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pay_bit(input int i);
        return int'(pay[i / 8][7 - (i % 8)]);
    endfunction

    function automatic int field(input int start, input int w);
        int v = 0;
        for (int j = 0; j < w; j++) v = (v << 1) | pay_bit(start + j);
        return v;
    endfunction

    task automatic put_field(input int pos, input int w, input int val);
        for (int j = 0; j < w; j++)
            pay[(pos + j) / 8][7 - ((pos + j) % 8)] = 1'((val >> (w - 1 - j)) & 1);
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) pay[i] = 8'($urandom);
    endtask

    // Frame-level reference: header length, word slicing and address limits
    // straight from the frame rules, using plain arithmetic on the payload bits.
    task automatic model_frame(input int cmd, input int len, input int nbits, input bit aborted);
        int  start;
        int  a;
        bit  ovf;
        exp_w.delete();
        exp_e.delete();
        exp_rdy = 0;
        ovf     = 1'b0;
        if (cmd > 1) begin
            exp_e.push_back(2'd2);
        end else begin
            start = (cmd == 0) ? 0 : ((nbits >= 16) ? field(0, 16) : 0);
            for (int k = 0; 16 + 12 * (k + 1) <= nbits; k++) begin
                a = start + k;
                if (a < c_chan) begin
                    exp_w.push_back({10'(a), 12'(field(16 + 12 * k, 12))});
                end else if (!ovf) begin
                    ovf = 1'b1;
                    exp_e.push_back(2'd3);
                end
            end
        end
        if (aborted) begin
            exp_e.push_back(2'd1);
        end else begin
            exp_rdy = 1;
            if (cmd == 0) begin
                exp_type = (nbits >= 6)  ? 6'(field(0, 6))   : 6'd0;
                exp_time = (nbits >= 16) ? 10'(field(6, 10)) : 10'd0;
            end
        end
        if (len * 8 < nbits) exp_rdy = 0;
    endtask

    task automatic start_capture();
        obs_w.delete();
        obs_e.delete();
        obs_rdy = 0;
        overlap = 0;
        wen_cyc = -100;
        rdy_cyc = -200;
    endtask

    task automatic send_bit(input int b);
        mosi = 1'(b);
        #40 dck = 1'b1;
        #40 dck = 1'b0;
    endtask

    task automatic send_frame(input int cmd, input int len, input int nbits);
        for (int i = c_cmd_w - 1; i >= 0; i--) send_bit((cmd >> i) & 1);
        for (int i = c_len_w - 1; i >= 0; i--) send_bit((len >> i) & 1);
        for (int i = 0; i < nbits; i++) send_bit(pay_bit(i));
    endtask

    task automatic compare(input string tag);
        int n;
        repeat (30) @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_nwrites"}, obs_w.size(), exp_w.size());
        n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_write%0d", tag, i), obs_w[i], exp_w[i]);
        check({tag, "_nerrs"}, obs_e.size(), exp_e.size());
        n = (obs_e.size() < exp_e.size()) ? obs_e.size() : exp_e.size();
        for (int i = 0; i < n; i++) check($sformatf("%s_err%0d", tag, i), obs_e[i], exp_e[i]);
        check({tag, "_ready"}, obs_rdy, exp_rdy);
        check({tag, "_overlap"}, overlap, 0);
        check({tag, "_type"}, typ, exp_type);
        check({tag, "_time"}, tim, exp_time);
    endtask

    task automatic run_frame(input string tag, input int cmd, input int len, input int nbits);
        model_frame(cmd, len, nbits, 1'b0);
        start_capture();
        cs = 1'b0;
        #30;
        send_frame(cmd, len, nbits);
        #40 cs = 1'b1;
        compare(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"}, wen, 1'b0);
        check({tag, "_addr"}, addr, '0);
        check({tag, "_data"}, data, '0);
        check({tag, "_type"}, typ, '0);
        check({tag, "_time"}, tim, '0);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_code"}, err_code, '0);
    endtask

    initial begin
        int cmd;
        int len;
        int sel;
        logic [5:0] old_type;
        logic [9:0] old_time;

        // Reset state.
        #12;
        check_all_zero("reset");
        #11 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Keyframe: type 0x05, time 0x123, words 0xABC / 0x456.
        fill_random();
        put_field(0, 6, 'h05);
        put_field(6, 10, 'h123);
        put_field(16, 12, 'hABC);
        put_field(28, 12, 'h456);
        run_frame("key", 0, 5, 40);
        check("key_w1_const", obs_w[1], {10'd1, 12'h456});
        check("key_type_const", typ, 6'h05);
        check("key_time_const", tim, 10'h123);
        check("key_type_before_ready", type_pre, 6'h00);
        check("key_time_before_ready", time_pre, 10'h000);
        check("key_ready_after_last_wen", rdy_cyc - wen_cyc, 1);

        // Offset write near the top of the buffer.
        fill_random();
        put_field(0, 16, 'h03BE);
        put_field(16, 12, 'h111);
        put_field(28, 12, 'h222);
        run_frame("off", 1, 5, 40);
        check("off_w0_const", obs_w[0], {10'd958, 12'h111});
        check("off_w1_const", obs_w[1], {10'd959, 12'h222});
        check("off_type_kept", typ, 6'h05);
        check("off_ready_after_last_wen", rdy_cyc - wen_cyc, 1);

        // Overflow: three words starting at the last channel, trailing bits ignored.
        fill_random();
        put_field(0, 16, 959);
        run_frame("ovf", 1, 7, 56);
        check("ovf_nwrites_const", obs_w.size(), 1);
        check("ovf_code_const", err_code, 2'd3);

        // Abort after 40 payload bits of a len=20 keyframe.
        old_type = exp_type;
        old_time = exp_time;
        fill_random();
        model_frame(0, 20, 40, 1'b1);
        start_capture();
        cs = 1'b0;
        #30;
        send_frame(0, 20, 40);
        #40 cs = 1'b1;
        compare("abort");
        check("abort_type_kept", typ, old_type);
        check("abort_time_kept", tim, old_time);
        check("abort_code_const", err_code, 2'd1);
        fill_random();
        run_frame("after_abort", 0, 5, 40);

        // Unknown command followed by a keyframe in the same cs window.
        fill_random();
        model_frame(7, 2, 16, 1'b0);
        start_capture();
        cs = 1'b0;
        #30;
        send_frame(7, 2, 16);
        compare("unk");
        check("unk_code_const", err_code, 2'd2);
        fill_random();
        model_frame(0, 5, 40, 1'b0);
        start_capture();
        send_frame(0, 5, 40);
        #40 cs = 1'b1;
        compare("b2b");
        check("b2b_code_held", err_code, 2'd2);

        // Randomized frames.
        for (int it = 0; it < 12; it++) begin
            fill_random();
            sel = int'($urandom_range(0, 2));
            if (sel == 0) begin
                cmd = 0;
                len = int'($urandom_range(2, 9));
            end else if (sel == 1) begin
                cmd = 1;
                len = int'($urandom_range(2, 9));
                put_field(0, 16, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                                             : int'($urandom_range(930, 965)));
            end else begin
                cmd = int'($urandom_range(2, 31));
                len = int'($urandom_range(0, 4));
            end
            run_frame($sformatf("rnd%0d", it), cmd, len, len * 8);
        end

        // Asynchronous reset in the middle of a payload.
        fill_random();
        cs = 1'b0;
        #30;
        send_frame(0, 10, 20);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("midreset");
        cs = 1'b1;
        #27 rst = 1'b0;
        exp_type = '0;
        exp_time = '0;
        repeat (5) @(posedge clk);
        run_frame("len0", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
